// File: rtl/csl_run_ctl.sv
// csl_run_ctl: console run-control for the KS-10 CPU.
// Holds RUN/HALT status and the console request flags. The microcode clears the
// request flags.
// Optional instruction N-step counter, built only when CSL_STEP_EN is defined.
// Without CSL_STEP_EN:
//   - the FSM has only STOP and RUN;
//   - the step inputs are ignored;
//   - the step outputs read 0.
// Every state update is qualified by clken. rst is synchronous and wins over clken.
// runState exposes the FSM state for debug: 0 = STOP, 1 = RUN, 2 = STEP.
module csl_run_ctl #(
   parameter int NCH = 2,
   parameter int CW  = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clken,
   input  logic          specCONS,
   input  logic          consSET_HALT,
   input  logic          consCLR_HALT,
   input  logic          consCLR_RUN,
   input  logic [NCH-1:0] consCLR,
   input  logic [NCH-1:0] cslREQ,
   input  logic          cslRUN,
   input  logic          cslHALT,
   input  logic          debugHALT,
   input  logic          cslSTEP,
   input  logic [CW-1:0] cslSTEPCNT,
   input  logic          instDONE,
   output logic          cpuRUN,
   output logic          cpuHALT,
   output logic [NCH-1:0] cpuREQ,
   output logic          stepBUSY,
   output logic [CW-1:0] stepREM,
   output logic          stepDONE,
   output logic [1:0]    runState
);

   typedef enum logic [1:0] {
      STOP = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } runState_t;

   runState_t state;
   runState_t stateNext;
   logic      halt;

   // Any halt source forces STOP, ahead of every other request.
   assign halt = (specCONS & consCLR_RUN) | cslHALT | debugHALT;

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= STOP;
      else if (clken)
         state <= stateNext;
   end

`ifdef CSL_STEP_EN
   logic [CW-1:0] remQ;
   logic [CW-1:0] remNext;
   logic          doneNext;

   // Next-state and step-count logic.
   // A zero count leaves the CPU stopped. The decrement is guarded so the
   // count can never wrap.
   always_comb begin
      stateNext = state;
      remNext   = remQ;
      doneNext  = 1'b0;
      if (halt) begin
         stateNext = STOP;
         remNext   = '0;
      end else begin
         case (state)
            STOP: begin
               if (cslSTEP) begin
                  if (cslSTEPCNT != '0) begin
                     stateNext = STEP;
                     remNext   = cslSTEPCNT;
                  end
               end else if (cslRUN) begin
                  stateNext = RUN;
               end
            end
            STEP: begin
               if (cslRUN) begin
                  stateNext = RUN;
                  remNext   = '0;
               end else if (instDONE && (remQ != '0)) begin
                  remNext = remQ - 1'b1;
                  if (remQ == {{(CW-1){1'b0}}, 1'b1}) begin
                     stateNext = STOP;
                     doneNext  = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Remaining-step counter.
   always_ff @(posedge clk) begin
      if (rst)
         remQ <= '0;
      else if (clken)
         remQ <= remNext;
   end

   // Completion pulse.
   // It is cleared on every clk edge, so it lasts exactly one clk cycle
   // even when clken drops.
   always_ff @(posedge clk) begin
      if (rst)
         stepDONE <= 1'b0;
      else
         stepDONE <= clken & doneNext;
   end

   // Output decode of the run state.
   always_comb begin
      cpuRUN   = (state != STOP);
      stepBUSY = (state == STEP);
      stepREM  = remQ;
      runState = state;
   end
`else
   logic unusedStep;

   // The step inputs are not used in this build.
   assign unusedStep = &{1'b0, cslSTEP, cslSTEPCNT, instDONE};

   // Next-state logic: STOP and RUN only.
   always_comb begin
      stateNext = state;
      if (halt)
         stateNext = STOP;
      else if ((state == STOP) && cslRUN)
         stateNext = RUN;
   end

   // Output decode; the step outputs are tied off.
   always_comb begin
      cpuRUN   = (state != STOP);
      stepBUSY = 1'b0;
      stepREM  = '0;
      stepDONE = 1'b0;
      runState = state;
   end
`endif

   // Halt status: when set and clear arrive together, set wins.
   always_ff @(posedge clk) begin
      if (rst)
         cpuHALT <= 1'b0;
      else if (clken) begin
         if (specCONS & consSET_HALT)
            cpuHALT <= 1'b1;
         else if (specCONS & consCLR_HALT)
            cpuHALT <= 1'b0;
      end
   end

   // Request flags: the console sets them and the microcode clears them.
   // When both arrive together, clear wins.
   always_ff @(posedge clk) begin
      if (rst)
         cpuREQ <= '0;
      else if (clken)
         cpuREQ <= (cpuREQ | cslREQ) & ~({NCH{specCONS}} & consCLR);
   end

endmodule

// File: tb/tb_csl_run_ctl.sv
// tb_csl_run_ctl: directed bench for csl_run_ctl.
// The step scenarios are compiled in only when CSL_STEP_EN is defined.
// Otherwise the bench checks that the step inputs have no effect.
module tb_csl_run_ctl;

   localparam int NCH = 2;
   localparam int CW  = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           clken;
   logic           specCONS;
   logic           consSET_HALT;
   logic           consCLR_HALT;
   logic           consCLR_RUN;
   logic [NCH-1:0] consCLR;
   logic [NCH-1:0] cslREQ;
   logic           cslRUN;
   logic           cslHALT;
   logic           debugHALT;
   logic           cslSTEP;
   logic [CW-1:0]  cslSTEPCNT;
   logic           instDONE;
   logic           cpuRUN;
   logic           cpuHALT;
   logic [NCH-1:0] cpuREQ;
   logic           stepBUSY;
   logic [CW-1:0]  stepREM;
   logic           stepDONE;
   logic [1:0]     runState;

   int checks   = 0;
   int failures = 0;
   logic [CW-1:0] expQ[$];

   csl_run_ctl #(.NCH(NCH), .CW(CW)) dut (
      .clk(clk), .rst(rst), .clken(clken), .specCONS(specCONS),
      .consSET_HALT(consSET_HALT), .consCLR_HALT(consCLR_HALT),
      .consCLR_RUN(consCLR_RUN), .consCLR(consCLR), .cslREQ(cslREQ),
      .cslRUN(cslRUN), .cslHALT(cslHALT), .debugHALT(debugHALT),
      .cslSTEP(cslSTEP), .cslSTEPCNT(cslSTEPCNT), .instDONE(instDONE),
      .cpuRUN(cpuRUN), .cpuHALT(cpuHALT), .cpuREQ(cpuREQ),
      .stepBUSY(stepBUSY), .stepREM(stepREM), .stepDONE(stepDONE),
      .runState(runState)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Single comparison point.
   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock edge.
   // Inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      specCONS = 0; consSET_HALT = 0; consCLR_HALT = 0; consCLR_RUN = 0;
      consCLR = '0; cslREQ = '0; cslRUN = 0; cslHALT = 0; debugHALT = 0;
      cslSTEP = 0; cslSTEPCNT = '0; instDONE = 0;
   endtask

   task automatic pulseRun();
      cslRUN = 1; tick(); cslRUN = 0;
   endtask

   task automatic startStep(input logic [CW-1:0] n);
      cslSTEP = 1; cslSTEPCNT = n; tick(); cslSTEP = 0; cslSTEPCNT = '0;
   endtask

   task automatic strobe();
      instDONE = 1; tick(); instDONE = 0;
   endtask

   initial begin
      clearInputs();
      clken = 1;
      rst = 1;
      tick(); tick();
      rst = 0;

      // Reset state.
      checkVal("rst_run",   cpuRUN,   0);
      checkVal("rst_halt",  cpuHALT,  0);
      checkVal("rst_req",   cpuREQ,   0);
      checkVal("rst_busy",  stepBUSY, 0);
      checkVal("rst_rem",   stepREM,  0);
      checkVal("rst_done",  stepDONE, 0);
      checkVal("rst_state", runState, 0);

      // RUN, then each of the three halt sources.
      pulseRun();
      checkVal("run_on", cpuRUN, 1);
      checkVal("run_state", runState, 1);
      cslHALT = 1; tick(); cslHALT = 0;
      checkVal("csl_halt", cpuRUN, 0);
      pulseRun();
      checkVal("run_on2", cpuRUN, 1);
      debugHALT = 1; tick(); debugHALT = 0;
      checkVal("debug_halt", cpuRUN, 0);
      pulseRun();
      checkVal("run_on3", cpuRUN, 1);
      specCONS = 1; consCLR_RUN = 1; tick(); specCONS = 0; consCLR_RUN = 0;
      checkVal("cons_clr_run", cpuRUN, 0);
      consCLR_RUN = 1; pulseRun(); consCLR_RUN = 0;
      checkVal("clr_run_needs_spec", cpuRUN, 1);
      cslHALT = 1; cslRUN = 1; tick(); clearInputs();
      checkVal("halt_beats_run", cpuRUN, 0);

      // Halt status.
      specCONS = 1; consSET_HALT = 1; consCLR_HALT = 1; tick(); clearInputs();
      checkVal("halt_set_wins", cpuHALT, 1);
      consCLR_HALT = 1; tick(); clearInputs();
      checkVal("halt_clr_needs_spec", cpuHALT, 1);
      specCONS = 1; consCLR_HALT = 1; tick(); clearInputs();
      checkVal("halt_clr", cpuHALT, 0);

      // Request flags.
      cslREQ = 2'b11; tick(); clearInputs();
      checkVal("req_set", cpuREQ, 2'b11);
      specCONS = 1; consCLR = 2'b10; cslREQ = 2'b10; tick(); clearInputs();
      checkVal("req_clr_wins", cpuREQ, 2'b01);
      consCLR = 2'b01; tick(); clearInputs();
      checkVal("req_clr_needs_spec", cpuREQ, 2'b01);
      specCONS = 1; consCLR = 2'b01; cslREQ = 2'b10; tick(); clearInputs();
      checkVal("req_independent", cpuREQ, 2'b10);

      // Inputs held while clken is low: no output may change.
      clken = 0;
      cslRUN = 1; specCONS = 1; consSET_HALT = 1; cslREQ = 2'b01; consCLR = 2'b10;
      tick(); tick();
      checkVal("clken_run", cpuRUN, 0);
      checkVal("clken_halt", cpuHALT, 0);
      checkVal("clken_req", cpuREQ, 2'b10);
      clearInputs();
      clken = 1;
      specCONS = 1; consCLR = 2'b11; tick(); clearInputs();
      checkVal("req_clear_all", cpuREQ, 0);

`ifdef CSL_STEP_EN
      // N-step with count 3, with idle cycles between the strobes.
      expQ = '{16'd3, 16'd2, 16'd1, 16'd0};
      startStep(16'd3);
      checkVal("step_busy", stepBUSY, 1);
      checkVal("step_run", cpuRUN, 1);
      checkVal("step_state", runState, 2);
      checkVal("step_rem_load", stepREM, expQ.pop_front());
      for (int i = 0; i < 3; i++) begin
         tick();
         checkVal("step_rem_idle", stepREM, 16'(3 - i));
         checkVal("step_done_idle", stepDONE, 0);
         strobe();
         checkVal("step_rem", stepREM, expQ.pop_front());
         checkVal("step_done", stepDONE, (i == 2) ? 1 : 0);
         checkVal("step_run_seq", cpuRUN, (i == 2) ? 0 : 1);
      end
      tick();
      checkVal("step_done_one_cycle", stepDONE, 0);
      checkVal("step_busy_end", stepBUSY, 0);
      strobe();
      checkVal("inst_in_stop_rem", stepREM, 0);
      checkVal("inst_in_stop_done", stepDONE, 0);

      // Abort the step into RUN.
      startStep(16'd5);
      strobe(); strobe();
      checkVal("abort_rem_mid", stepREM, 3);
      cslSTEP = 1; cslSTEPCNT = 16'd9; tick(); clearInputs();
      checkVal("step_ignored_in_step", stepREM, 3);
      pulseRun();
      checkVal("abort_run", cpuRUN, 1);
      checkVal("abort_busy", stepBUSY, 0);
      checkVal("abort_rem", stepREM, 0);
      checkVal("abort_done", stepDONE, 0);
      strobe();
      checkVal("inst_in_run_rem", stepREM, 0);
      checkVal("inst_in_run_done", stepDONE, 0);
      cslHALT = 1; tick(); cslHALT = 0;

      // A zero count is ignored, and STEP beats a simultaneous RUN.
      startStep(16'd0);
      checkVal("cnt0_run", cpuRUN, 0);
      checkVal("cnt0_done", stepDONE, 0);
      cslRUN = 1; startStep(16'd2); cslRUN = 0;
      checkVal("step_beats_run", stepBUSY, 1);
      checkVal("step_beats_run_rem", stepREM, 2);
      cslHALT = 1; tick(); cslHALT = 0;
      checkVal("halt_clears_rem", stepREM, 0);

      // Halt arriving with the final strobe.
      startStep(16'd1);
      cslHALT = 1; instDONE = 1; tick(); clearInputs();
      checkVal("halt_final_run", cpuRUN, 0);
      checkVal("halt_final_done", stepDONE, 0);
      checkVal("halt_final_rem", stepREM, 0);

      // The completion pulse still lasts exactly one cycle when clken drops.
      startStep(16'd1);
      strobe();
      checkVal("done_pulse", stepDONE, 1);
      clken = 0; tick();
      checkVal("done_clken_low", stepDONE, 0);
      clken = 1;

      // Strobes with clken low are not consumed.
      startStep(16'd2);
      clken = 0; strobe(); clken = 1;
      checkVal("clken_inst", stepREM, 2);

      // Reset in the middle of a step.
      specCONS = 1; consSET_HALT = 1; cslREQ = 2'b11; tick(); clearInputs();
      startStep(16'd4);
      rst = 1; clken = 0; instDONE = 1; tick(); rst = 0; clken = 1; instDONE = 0;
      checkVal("rstmid_run", cpuRUN, 0);
      checkVal("rstmid_halt", cpuHALT, 0);
      checkVal("rstmid_req", cpuREQ, 0);
      checkVal("rstmid_busy", stepBUSY, 0);
      checkVal("rstmid_rem", stepREM, 0);
      checkVal("rstmid_done", stepDONE, 0);
`else
      // Without the step feature, the step inputs have no effect.
      startStep(16'd4);
      checkVal("nostep_run", cpuRUN, 0);
      checkVal("nostep_busy", stepBUSY, 0);
      checkVal("nostep_rem", stepREM, 0);
      checkVal("nostep_done", stepDONE, 0);
      strobe();
      checkVal("nostep_inst_run", cpuRUN, 0);
      checkVal("nostep_inst_done", stepDONE, 0);
      pulseRun();
      checkVal("nostep_run_ok", cpuRUN, 1);

      // Reset while running.
      specCONS = 1; consSET_HALT = 1; cslREQ = 2'b11; tick(); clearInputs();
      rst = 1; clken = 0; tick(); rst = 0; clken = 1;
      checkVal("rstmid_run", cpuRUN, 0);
      checkVal("rstmid_halt", cpuHALT, 0);
      checkVal("rstmid_req", cpuREQ, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/csl_run_ctl.md
# csl_run_ctl

Parametrised console run-control block for the KS-10 CPU, sitting between the console interface and the microsequencer. It holds the RUN and HALT status, plus NCH console request flags that the console sets and the microcode clears (CONT, EXEC, spare). It adds an instruction single-step/N-step counter that runs the CPU for a programmed number of instructions and then drops RUN. All state advances only on `clken`-qualified clock edges.

## Interface
Parameters:
- `NCH`, 2: number of console request flags (bit 0 CONT, bit 1 EXEC, higher bits spare).
- `CW`, 16: step counter width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `clken` in 1: clock enable; qualifies every state update.
- `specCONS` in 1: decoded microcode CONS special-function strobe.
- `consSET_HALT`, `consCLR_HALT`, `consCLR_RUN` in 1 each: microcode CONS field bits; effective only with `specCONS`.
- `consCLR` in NCH: per-flag microcode clear bits; effective only with `specCONS`.
- `cslREQ` in NCH: console request set pulses.
- `cslRUN`, `cslHALT` in 1 each: console run and halt switches.
- `debugHALT` in 1: breakpoint halt.
- `cslSTEP` in 1: start N-step.
- `cslSTEPCNT` in CW: number of instructions to step.
- `instDONE` in 1: microcode instruction-boundary strobe.
- `cpuRUN` out 1: run status.
- `cpuHALT` out 1: halt status.
- `cpuREQ` out NCH: request flags.
- `stepBUSY` out 1: run state is STEP.
- `stepREM` out CW: remaining step count.
- `stepDONE` out 1: one-clk pulse on step completion.

## Operation
- The run FSM has three states: STOP, RUN and STEP. `cpuRUN` = (state != STOP); `stepBUSY` = (state == STEP).
- Priority per enabled edge, highest first:
  1. `halt` = `(specCONS & consCLR_RUN) | cslHALT | debugHALT`: go to STOP and clear `stepREM`.
  2. In STOP with `cslSTEP`:
     - If `cslSTEPCNT != 0`: go to STEP and load `stepREM` with `cslSTEPCNT`.
     - If `cslSTEPCNT == 0`: ignored, stay in STOP, and no `stepDONE` pulse.
     - `cslSTEP` beats a simultaneous `cslRUN`.
  3. In STOP with `cslRUN`: go to RUN.
  4. In STEP with `cslRUN`: go to RUN, clear `stepREM`, and do not pulse `stepDONE`.
  5. In STEP with `instDONE`: `stepREM` decrements by 1.
     - If `stepREM == 1`: go to STOP, `stepREM` becomes 0, and pulse `stepDONE`.
- Ignored inputs: `cslSTEP` in RUN or STEP; `instDONE` in STOP or RUN.
- `stepREM` is unsigned, CW bits, and never wraps; the decrement happens only when the value is nonzero.
- `cpuHALT`: set by `specCONS & consSET_HALT`, cleared by `specCONS & consCLR_HALT`. Set wins when both are present.
- `cpuREQ[i]`: cleared by `specCONS & consCLR[i]`, set by `cslREQ[i]`. Clear wins when both are present. Flags are independent of each other and of the FSM.

## Timing
- Reset: every output reads 0 and the FSM is in STOP.
  - `rst` overrides `clken`.
  - Reset during STEP aborts the step without a `stepDONE` pulse.
- All outputs are registered. Each one reflects its inputs one enabled edge later. Inputs are sampled only when `clken` = 1.
- `stepDONE` is high for exactly one `clk` cycle following the enabled edge that completes the step, regardless of `clken` on the next cycle.
- Step completion: `cpuRUN` falls on the same edge as the final `instDONE` is taken. With `cslSTEPCNT` = N, exactly N `instDONE` strobes are consumed.
- Halt on the same edge as the final `instDONE`: the halt wins and no `stepDONE` pulse is produced.

## Configuration
- `CSL_STEP_EN` defined: STEP state, step counter and step ports are functional as described above.
- `CSL_STEP_EN` undefined:
  - No STEP state and no counter logic are built.
  - `cslSTEP`, `cslSTEPCNT` and `instDONE` are ignored.
  - `stepBUSY`, `stepREM` and `stepDONE` are tied to 0.
  - RUN, HALT and request-flag behaviour is unchanged.

## Test plan
- Reset, then `cslRUN` pulse with `clken`=1 -> `cpuRUN`=1 next edge; then `cslHALT` -> `cpuRUN`=0; `debugHALT` and `specCONS`+`consCLR_RUN` behave identically.
- `cslSTEP` with `cslSTEPCNT`=3, then 3 `instDONE` strobes spaced by idle cycles -> `stepREM` reads 3,2,1,0; `cpuRUN` drops on the 3rd strobe; exactly one `stepDONE` clk pulse.
- STEP with count 5, then `cslRUN` after 2 strobes -> RUN, `stepREM`=0, no `stepDONE`; a separate run with `cslSTEPCNT`=0 -> stays STOP, no pulse.
- `cslHALT` coincident with the final `instDONE` (count 1) -> STOP, `stepDONE`=0; `rst` mid-step -> all outputs 0.
- `specCONS` with `consSET_HALT` and `consCLR_HALT` together -> `cpuHALT`=1; `cslREQ[1]` with `consCLR[1]` together -> `cpuREQ[1]`=0; inputs held with `clken`=0 -> no output change.
- Build without `CSL_STEP_EN`: `cslSTEP` with count 4 -> `cpuRUN` stays 0, and `stepBUSY`, `stepREM` and `stepDONE` stay 0.
